// File: rtl/conv2_seq_ctrl.sv
// conv2 frame sequencer: streams one 3-channel feature map from the pool1 RAMs into the
// conv2 datapath, tags pointwise results with row/col and flags watchdog/surplus errors.
module conv2_seq_ctrl #(
  parameter int unsigned IMG_W     = 12,
  parameter int unsigned IMG_H     = 12,
  parameter int unsigned K         = 5,
  parameter int unsigned DATA_BITS = 15,
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 hold,
  output logic                 rd_en,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [DATA_BITS-1:0] ram_q_0,
  input  logic [DATA_BITS-1:0] ram_q_1,
  input  logic [DATA_BITS-1:0] ram_q_2,
  output logic                 valid_in,
  output logic [DATA_BITS-1:0] data_in_0,
  output logic [DATA_BITS-1:0] data_in_1,
  output logic [DATA_BITS-1:0] data_in_2,
  input  logic                 conv_valid_out,
  output logic                 wr_en,
  output logic [2:0]           out_row,
  output logic [2:0]           out_col,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned NPIX        = IMG_W * IMG_H;
  localparam int unsigned OUT_W       = IMG_W - K + 1;
  localparam int unsigned OUT_H       = IMG_H - K + 1;
  localparam int unsigned COORD_BITS  = 3;
  localparam int unsigned WD_BITS     = $clog2(TIMEOUT + 1);
  localparam int unsigned WIN_BITS    = 5;
  localparam int unsigned SURPLUS_WIN = 16;

  localparam logic [ADDR_BITS-1:0]  LAST_ADDR = ADDR_BITS'(NPIX - 1);
  localparam logic [COORD_BITS-1:0] LAST_COL  = COORD_BITS'(OUT_W - 1);
  localparam logic [COORD_BITS-1:0] LAST_ROW  = COORD_BITS'(OUT_H - 1);
  localparam logic [WD_BITS-1:0]    WD_LIMIT  = WD_BITS'(TIMEOUT);
  localparam logic [WIN_BITS-1:0]   WIN_LOAD  = WIN_BITS'(SURPLUS_WIN);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  state_t                 state_q, state_nxt;
  logic                   rd_en_nxt;
  logic [ADDR_BITS-1:0]   rd_addr_nxt;
  logic [COORD_BITS-1:0]  row_q, col_q, row_nxt, col_nxt;
  logic [WD_BITS-1:0]     wdog_q, wdog_nxt;
  logic [WIN_BITS-1:0]    win_q, win_nxt;
  logic                   err_nxt, done_nxt;
  logic                   count_c, surplus_c;
  logic                   rd_en_d;

  // Next-state and next-output logic; done holds the FSM in FEED/DRAIN for one extra cycle.
  always_comb begin
    state_nxt   = state_q;
    rd_en_nxt   = 1'b0;
    rd_addr_nxt = rd_addr;
    row_nxt     = row_q;
    col_nxt     = col_q;
    wdog_nxt    = '0;
    win_nxt     = win_q;
    err_nxt     = err;
    done_nxt    = 1'b0;
    count_c     = conv_valid_out && (state_q != IDLE) && !done;
    surplus_c   = conv_valid_out && (done || ((state_q == IDLE) && (win_q != '0)));

    if (surplus_c) err_nxt = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (win_q != '0) win_nxt = win_q - WIN_BITS'(1);
        if (start) begin
          state_nxt   = FEED;
          rd_en_nxt   = 1'b1;
          rd_addr_nxt = '0;
          row_nxt     = '0;
          col_nxt     = '0;
          win_nxt     = '0;
          err_nxt     = 1'b0;
        end
      end
      FEED: begin
        if (rd_en && (rd_addr == LAST_ADDR)) begin
          state_nxt   = DRAIN;
          rd_addr_nxt = '0;
        end else begin
          rd_en_nxt   = !hold;
          rd_addr_nxt = rd_addr + ADDR_BITS'(rd_en);
        end
      end
      DRAIN: begin
        // Holds the number of DRAIN cycles elapsed since the last result.
        wdog_nxt = count_c ? WD_BITS'(1) : wdog_q + WD_BITS'(1);
        if (wdog_nxt == WD_LIMIT) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (count_c) begin
      if (col_q == LAST_COL) begin
        col_nxt = '0;
        row_nxt = (row_q == LAST_ROW) ? '0 : row_q + COORD_BITS'(1);
      end else begin
        col_nxt = col_q + COORD_BITS'(1);
      end
      done_nxt = (row_q == LAST_ROW) && (col_q == LAST_COL);
    end

    if (done) begin
      state_nxt   = IDLE;
      rd_en_nxt   = 1'b0;
      rd_addr_nxt = '0;
      win_nxt     = WIN_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      row_q     <= '0;
      col_q     <= '0;
      wdog_q    <= '0;
      win_q     <= '0;
      err       <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      rd_en_d   <= 1'b0;
      valid_in  <= 1'b0;
      data_in_0 <= '0;
      data_in_1 <= '0;
      data_in_2 <= '0;
    end else begin
      state_q   <= state_nxt;
      rd_en     <= rd_en_nxt;
      rd_addr   <= rd_addr_nxt;
      row_q     <= row_nxt;
      col_q     <= col_nxt;
      wdog_q    <= wdog_nxt;
      win_q     <= win_nxt;
      err       <= err_nxt;
      done      <= done_nxt;
      busy      <= (state_nxt != IDLE);
      // RAM latency 1 plus one output register.
      rd_en_d   <= rd_en;
      valid_in  <= rd_en_d;
      data_in_0 <= ram_q_0;
      data_in_1 <= ram_q_1;
      data_in_2 <= ram_q_2;
    end
  end

  assign wr_en   = count_c;
  assign out_row = row_q;
  assign out_col = col_q;

endmodule

// File: tb/tb_conv2_seq_ctrl.sv
// Directed bench for conv2_seq_ctrl: frame table plus hand sequences for done, surplus,
// watchdog and mid-frame reset.
module tb_conv2_seq_ctrl;

  localparam int NPIX    = 144;
  localparam int OUT_W   = 8;
  localparam int RES_VIN = 53;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic        conv_valid_out = 1'b0;
  logic        rd_en, valid_in, wr_en, busy, done, err;
  logic [7:0]  rd_addr;
  logic [14:0] ram_q_0 = '0, ram_q_1 = '0, ram_q_2 = '0;
  logic [14:0] data_in_0, data_in_1, data_in_2;
  logic [2:0]  out_row, out_col;

  conv2_seq_ctrl #(.TIMEOUT(1023)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .ram_q_0(ram_q_0), .ram_q_1(ram_q_1), .ram_q_2(ram_q_2),
    .valid_in(valid_in), .data_in_0(data_in_0), .data_in_1(data_in_1), .data_in_2(data_in_2),
    .conv_valid_out(conv_valid_out), .wr_en(wr_en), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Feature RAM model: one-cycle read latency, contents derived from the address.
  always @(posedge clk) begin
    if (rd_en) begin
      ram_q_0 <= 15'(rd_addr);
      ram_q_1 <= 15'(rd_addr) + 15'd100;
      ram_q_2 <= 15'h7fff ^ 15'(rd_addr);
    end
  end

  typedef struct {
    int hold_addr;
    int n_res;
    bit corner;
    int abort_addr;
    int exp_span;
    int exp_stalls;
    int exp_done;
    int exp_tmo;
  } vec_t;

  vec_t vecs [5];
  int   n_cmp = 0, n_bad = 0, cyc = 0;
  int   exp_rd, exp_vin, rd_cnt, vin_cnt, wr_idx, done_cnt, stalls;
  int   first_rd, last_rd, first_vin, last_vin;
  int   res_sent, hold_left, last_res, err_cyc;
  bit   hold_done, ms_done, cvo;
  logic wr_seen;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_rd_addr"}, int'(rd_addr), 0);
    chk({tag, "_valid_in"}, int'(valid_in), 0);
    chk({tag, "_data_in_0"}, int'(data_in_0), 0);
    chk({tag, "_data_in_1"}, int'(data_in_1), 0);
    chk({tag, "_data_in_2"}, int'(data_in_2), 0);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_out_row"}, int'(out_row), 0);
    chk({tag, "_out_col"}, int'(out_col), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  // One clock: sample mid-cycle, then return 1 ns after the next rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    wr_seen = wr_en;
    if (rd_en) begin
      chk("rd_addr", int'(rd_addr), exp_rd);
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
      exp_rd++;
      rd_cnt++;
    end else if (busy && rd_cnt > 0 && rd_cnt < NPIX) begin
      stalls++;
      chk("stall_addr", int'(rd_addr), exp_rd);
    end
    if (valid_in) begin
      chk("data_in_0", int'(data_in_0), exp_vin);
      chk("data_in_1", int'(data_in_1), exp_vin + 100);
      chk("data_in_2", int'(data_in_2), 32767 ^ exp_vin);
      if (first_vin < 0) first_vin = cyc;
      last_vin = cyc;
      exp_vin++;
      vin_cnt++;
    end
    if (wr_en) begin
      chk("out_row", int'(out_row), wr_idx / OUT_W);
      chk("out_col", int'(out_col), wr_idx % OUT_W);
      wr_idx++;
    end
    if (done) done_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{-1, 64, 1'b1, -1, 143, 0, 1, -1};
    vecs[1] = '{40, 64, 1'b0, -1, 148, 5, 1, -1};
    vecs[2] = '{-1, 63, 1'b0, -1, 143, 0, 0, 1023};
    vecs[3] = '{-1, 64, 1'b0, 70, 0, 0, 0, -1};
    vecs[4] = '{-1, 64, 1'b0, -1, 143, 0, 1, -1};

    #1 rst_n = 1'b0;
    #2 check_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      vec_t cv;
      cv = vecs[v];
      exp_rd = 0; exp_vin = 0; rd_cnt = 0; vin_cnt = 0; wr_idx = 0; done_cnt = 0; stalls = 0;
      first_rd = -1; last_rd = -1; first_vin = -1; last_vin = -1;
      res_sent = 0; hold_left = 0; last_res = -1; hold_done = 1'b0; ms_done = 1'b0;

      start = 1'b1;
      step();
      start = 1'b0;
      chk("busy_rise", int'(busy), 1);
      chk("err_clear", int'(err), 0);

      for (int i = 0; i < 1000; i++) begin
        if (res_sent == cv.n_res && rd_cnt == NPIX && vin_cnt == NPIX) break;
        if (cv.abort_addr >= 0 && exp_rd == cv.abort_addr) break;
        cvo = (res_sent < cv.n_res) && (vin_cnt >= RES_VIN) && (i % 2 == 0);
        conv_valid_out = cvo;
        if (hold_left == 0 && !hold_done && cv.hold_addr >= 0 && exp_rd == cv.hold_addr - 1) begin
          hold_left = 5;
          hold_done = 1'b1;
        end
        hold = (hold_left > 0);
        if (hold_left > 0) hold_left--;
        start = cv.corner && (exp_rd == 70) && !ms_done;
        if (start) ms_done = 1'b1;
        step();
        chk("wr_en", int'(wr_seen), int'(cvo));
        if (cvo) begin
          res_sent++;
          last_res = cyc;
        end
      end
      conv_valid_out = 1'b0;
      hold = 1'b0;
      start = 1'b0;

      if (cv.abort_addr >= 0) begin
        chk("abort_rd_cnt", rd_cnt, cv.abort_addr);
        #2 rst_n = 1'b0;
        #1 check_zero("midreset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        continue;
      end

      chk("rd_cnt", rd_cnt, NPIX);
      chk("vin_cnt", vin_cnt, NPIX);
      chk("res_cnt", wr_idx, cv.n_res);
      chk("rd_span", last_rd - first_rd, cv.exp_span);
      chk("vin_span", last_vin - first_vin, cv.exp_span);
      chk("vin_latency", first_vin - first_rd, 2);
      chk("stalls", stalls, cv.exp_stalls);

      if (cv.exp_done != 0) begin
        chk("done_pulse", int'(done), 1);
        chk("busy_at_done", int'(busy), 1);
        start = cv.corner;
        step();
        start = 1'b0;
        chk("done_low", int'(done), 0);
        chk("busy_fall", int'(busy), 0);
        chk("no_restart_1", int'(rd_en), 0);
        chk("err_after_done", int'(err), 0);
        step();
        chk("no_restart_2", int'(rd_en), 0);
        chk("idle_busy", int'(busy), 0);
        if (cv.corner) begin
          step();
          conv_valid_out = 1'b1;
          step();
          conv_valid_out = 1'b0;
          chk("surplus_wr_en", int'(wr_seen), 0);
          chk("surplus_err", int'(err), 1);
          step();
          chk("err_sticky", int'(err), 1);
        end
        chk("done_count", done_cnt, 1);
      end else begin
        err_cyc = -1;
        for (int i = 0; i < 1100; i++) begin
          if (err) begin
            err_cyc = cyc + 1;
            break;
          end
          step();
        end
        chk("timeout_gap", err_cyc - last_res, cv.exp_tmo);
        chk("timeout_busy", int'(busy), 0);
        chk("timeout_no_done", done_cnt, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
